// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and tree-PLRU helpers for the N-way I-cache
//
// Purpose : controller state encoding, line geometry constants and the
//           tree-PLRU victim/update functions used by icache_plru_tree.
//           The functions take the way count as an argument and work on a
//           7-bit (8-way) bit vector; narrower trees use the low bits.
// Tree layout: node 0 is the root, children of node n are 2n+1 (lower half
//           of the ways) and 2n+2 (upper half). A node bit of 0 sends the
//           victim search to the lower half, 1 to the upper half.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALLOC = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  localparam int LINE_W        = 128;
  localparam int WORD_W        = 32;
  localparam int WORD_OFF_BITS = 2;
  localparam int MAX_PLRU_W    = 7;

  function automatic int plru_levels(input int ways);
    return (ways >= 8) ? 3 : (ways >= 4) ? 2 : (ways >= 2) ? 1 : 0;
  endfunction

  // Follow the node bits from the root; the way number is built MSB first.
  function automatic logic [2:0] plru_victim(input logic [MAX_PLRU_W-1:0] bits,
                                             input int ways);
    logic [2:0] way;
    int         node;
    int         lv;
    way  = '0;
    node = 0;
    lv   = plru_levels(ways);
    for (int l = 0; l < 3; l++) begin
      if (l < lv) begin
        way  = {way[1:0], bits[3'(node)]};
        node = 2 * node + 1 + (bits[3'(node)] ? 1 : 0);
      end
    end
    return way;
  endfunction

  // Make every node on the path to 'way' point at the opposite half, so the
  // most recently used way is the last one the victim search reaches.
  function automatic logic [MAX_PLRU_W-1:0] plru_update(input logic [MAX_PLRU_W-1:0] bits,
                                                        input logic [2:0] way,
                                                        input int ways);
    logic [MAX_PLRU_W-1:0] nb;
    logic                  dir;
    int                    node;
    int                    lv;
    nb   = bits;
    node = 0;
    lv   = plru_levels(ways);
    for (int l = 0; l < 3; l++) begin
      if (l < lv) begin
        dir            = way[2'(lv - 1 - l)];
        nb[3'(node)]   = ~dir;
        node           = 2 * node + 1 + (dir ? 1 : 0);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/icache_plru_tree.sv
// rtl/icache_plru_tree.sv - combinational tree-PLRU victim select and update for one set
//
// Purpose : given the PLRU bits of one set, report the PLRU victim way and the
//           bits that result from marking 'upd_way' most recently used.
// Ports   : plru      in  PW  current PLRU bits of the set
//           upd_way   in  WB  way being touched (hit way or filled way)
//           victim    out WB  PLRU victim way
//           plru_next out PW  PLRU bits after touching upd_way
// With WAYS=1 there is no tree: victim is 0 and the 1-bit vector is a dummy.
module icache_plru_tree
  import icache_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PW-1:0] plru,
  input  logic [WB-1:0] upd_way,
  output logic [WB-1:0] victim,
  output logic [PW-1:0] plru_next
);

  logic [MAX_PLRU_W-1:0] ext;

  assign ext       = MAX_PLRU_W'(plru);
  assign victim    = WB'(plru_victim(ext, WAYS));
  assign plru_next = PW'(plru_update(ext, 3'(upd_way), WAYS));

endmodule

// File: rtl/cache_ro_nway.sv
// rtl/cache_ro_nway.sv - N-way set-associative read-only instruction cache
//
// Purpose : zero-latency hit path for the fetch port, line refill over a
//           128-bit request/ready memory port, invalid-first then tree-PLRU
//           replacement. Optional performance counters under the macro
//           ICACHE_PERF_CNT_EN (undefined: acc_cnt/miss_cnt tied to 0).
// Ports   : clk         in   1    rising-edge clock
//           proc_reset  in   1    asynchronous active-high reset
//           proc_read   in   1    fetch request
//           proc_addr   in   30   word address
//           proc_rdata  out  32   fetched word (holds last hit word otherwise)
//           proc_stall  out  1    pipeline stall
//           proc_hit    out  1    hit pulse in IDLE
//           mem_read    out  1    line read request (ALLOC)
//           mem_write   out  1    constant 0
//           mem_addr    out  28   line address
//           mem_wdata   out  128  constant 0
//           mem_rdata   in   128  returned line
//           mem_ready   in   1    line valid this cycle
//           acc_cnt     out  32   completed accesses
//           miss_cnt    out  32   misses
module cache_ro_nway
  import icache_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               proc_read,
  input  logic [29:0]        proc_addr,
  output logic [WORD_W-1:0]  proc_rdata,
  output logic               proc_stall,
  output logic               proc_hit,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic [31:0]        acc_cnt,
  output logic [31:0]        miss_cnt
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int IW    = (SET_BITS > 0) ? SET_BITS : 1;
  localparam int TAG_W = 28 - SET_BITS;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [PW-1:0]     plru_q  [SETS];

  logic [27:0]       line_q;
  logic [WB-1:0]     victim_q;
  logic [WORD_W-1:0] rdata_q;

  logic [IW-1:0]     cur_idx, fill_idx, plru_idx;
  logic [TAG_W-1:0]  cur_tag, fill_tag;

  logic              hit_any, inv_any, lookup_hit, miss;
  logic [WB-1:0]     hit_way, inv_way, victim_sel, plru_way, plru_vic;
  logic [PW-1:0]     plru_nxt;
  logic [LINE_W-1:0] hit_line;
  logic [WORD_W-1:0] hit_word;

  generate
    if (SET_BITS > 0) begin : g_idx
      assign cur_idx  = proc_addr[SET_BITS+1:2];
      assign fill_idx = line_q[SET_BITS-1:0];
    end else begin : g_no_idx
      assign cur_idx  = '0;
      assign fill_idx = '0;
    end
  endgenerate

  assign cur_tag  = proc_addr[29:SET_BITS+2];
  assign fill_tag = line_q[27:SET_BITS];

  // Parallel tag compare over all ways of the indexed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
      end
    end
  end

  // Scan downwards so the lowest-index invalid way wins.
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[cur_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WB'(w);
      end
    end
  end

  assign lookup_hit = (state_q == S_IDLE) && proc_read && hit_any;
  assign miss       = (state_q == S_IDLE) && proc_read && !hit_any;
  assign hit_line   = data_q[cur_idx][hit_way];
  assign hit_word   = hit_line[{proc_addr[WORD_OFF_BITS-1:0], 5'b0} +: WORD_W];
  assign victim_sel = inv_any ? inv_way : plru_vic;

  // One tree serves both uses: lookup/victim on the addressed set in IDLE,
  // and the post-fill update on the latched set in FILL.
  assign plru_idx = (state_q == S_FILL) ? fill_idx : cur_idx;
  assign plru_way = (state_q == S_FILL) ? victim_q : hit_way;

  icache_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru      (plru_q[plru_idx]),
    .upd_way   (plru_way),
    .victim    (plru_vic),
    .plru_next (plru_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss) state_d = S_ALLOC;
      S_ALLOC: if (mem_ready) state_d = S_FILL;
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      line_q   <= '0;
      victim_q <= '0;
      rdata_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (miss) begin
        line_q   <= proc_addr[29:2];
        victim_q <= victim_sel;
      end
      if (lookup_hit) begin
        rdata_q          <= hit_word;
        plru_q[cur_idx]  <= plru_nxt;
      end
      if (state_q == S_FILL) begin
        valid_q[fill_idx][victim_q] <= 1'b1;
        plru_q[fill_idx]            <= plru_nxt;
      end
    end
  end

  // The line is only guaranteed on mem_rdata in the mem_ready cycle, so the
  // data and tag are written then; the victim cannot be looked up again
  // before FILL has set its valid bit because lookups only happen in IDLE.
  always_ff @(posedge clk) begin
    if ((state_q == S_ALLOC) && mem_ready) begin
      tag_q[fill_idx][victim_q]  <= fill_tag;
      data_q[fill_idx][victim_q] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] acc_q, miss_q;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      acc_q  <= '0;
      miss_q <= '0;
    end else begin
      if (lookup_hit && (acc_q != '1)) acc_q <= acc_q + 32'd1;
      if (miss && (miss_q != '1)) miss_q <= miss_q + 32'd1;
    end
  end

  assign acc_cnt  = acc_q;
  assign miss_cnt = miss_q;
`else
  assign acc_cnt  = '0;
  assign miss_cnt = '0;
`endif

  assign proc_rdata = lookup_hit ? hit_word : rdata_q;
  assign proc_hit   = lookup_hit;
  assign proc_stall = (state_q != S_IDLE) || miss;
  assign mem_read   = (state_q == S_ALLOC);
  assign mem_addr   = line_q;
  assign mem_write  = 1'b0;
  assign mem_wdata  = '0;

endmodule

// File: tb/tb_cache_ro_nway.sv
// tb/tb_cache_ro_nway.sv - scoreboard bench for cache_ro_nway against a timestamp PLRU model
module tb_cache_ro_nway;

  localparam int WAYS     = 4;
  localparam int SET_BITS = 3;
  localparam int SETS     = 1 << SET_BITS;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         proc_hit;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  acc_cnt;
  logic [31:0]  miss_cnt;

  cache_ro_nway #(.WAYS(WAYS), .SET_BITS(SET_BITS)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_addr  (proc_addr),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .proc_hit   (proc_hit),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .acc_cnt    (acc_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: a fixed function of line address and word.
  function automatic logic [31:0] mem_word(input logic [27:0] line, input logic [1:0] k);
    if (line == 28'h4 && k == 2'd0) return 32'hDEADBEEF;
    return {line[19:0], 10'h2A5, k} ^ 32'h5A5A0000;
  endfunction

  // Reference model: per-way valid/tag plus last-use time. Tree-PLRU is the
  // recursive rule "descend into the half whose newest use is older".
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int unsigned m_ts    [SETS][WAYS];
  int unsigned tick;
  int          m_acc, m_miss;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_ts[s][w]    = 0;
      end
    m_acc  = 0;
    m_miss = 0;
  endtask

  function automatic int unsigned newest(input int s, input int lo, input int hi);
    int unsigned m = 0;
    for (int w = lo; w < hi; w++) if (m_ts[s][w] > m) m = m_ts[s][w];
    return m;
  endfunction

  function automatic int tree_victim(input int s);
    int lo = 0, hi = WAYS, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (newest(s, lo, mid) <= newest(s, mid, hi)) hi = mid;
      else lo = mid;
    end
    return lo;
  endfunction

  task automatic model_access(input logic [29:0] addr, output bit miss);
    int unsigned a, t;
    int s, w;
    a = 32'(addr);
    s = int'((a >> 2) % SETS);
    t = a >> (2 + SET_BITS);
    w = -1;
    m_acc++;
    for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    miss = (w < 0);
    if (miss) begin
      m_miss++;
      for (int i = 0; i < WAYS; i++) if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0) w = tree_victim(s);
      m_valid[s][w] = 1;
      m_tag[s][w]   = t;
    end
    tick++;
    m_ts[s][w] = tick;
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
    bit          miss;
    logic [27:0] line;
  } exp_t;

  exp_t sb[$];

  // Memory responder: mem_ready on the mem_lat-th request cycle, random
  // spurious mem_ready with junk data whenever no request is pending.
  int mem_lat   = 3;
  int alloc_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (proc_reset) begin
      alloc_cnt = 0;
      mem_ready = 1'b0;
    end else if (mem_read) begin
      alloc_cnt++;
      if (alloc_cnt == mem_lat) begin
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] = mem_word(mem_addr, 2'(k));
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      alloc_cnt = 0;
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Monitor: counts stall cycles and request starts, checks on every hit.
  int          stall_cnt  = 0;
  bit          rd_seen    = 0;
  bit          prev_mread = 0;
  logic [27:0] seen_line  = '0;

  always @(negedge clk) begin
    exp_t e;
    if (proc_reset) begin
      stall_cnt  = 0;
      rd_seen    = 0;
      prev_mread = 0;
    end else begin
      if (proc_stall) stall_cnt++;
      if (mem_read && !prev_mread) begin
        rd_seen   = 1;
        seen_line = mem_addr;
      end
      prev_mread = mem_read;
      if (proc_hit) begin
        check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rdata", 128'(proc_rdata), 128'(e.rdata));
          check("stall_cycles", 128'(stall_cnt), 128'(e.stalls));
          check("miss_seen", 128'(rd_seen), 128'(e.miss));
          if (e.miss) check("mem_addr", 128'(seen_line), 128'(e.line));
        end
        stall_cnt = 0;
        rd_seen   = 0;
      end
    end
  end

  // All stimulus changes happen at posedge+1.
  task automatic do_read(input logic [29:0] addr, input int lat);
    exp_t e;
    bit   miss, done, scr, h, mr;
    int   gap;
    model_access(addr, miss);
    e.rdata  = mem_word(addr[29:2], addr[1:0]);
    e.miss   = miss;
    e.line   = addr[29:2];
    e.stalls = miss ? lat + 2 : 0;
    sb.push_back(e);
    mem_lat   = lat;
    proc_addr = addr;
    proc_read = 1'b1;
    done = 0;
    scr  = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      h  = proc_hit;
      mr = mem_read;
      if (h) done = 1;
      else begin
        @(posedge clk);
        #1;
        if (mr) begin
          if ($urandom_range(0, 1) == 1) begin
            proc_addr = 30'($urandom);
            proc_read = 1'($urandom_range(0, 1));
            scr = 1;
          end
        end else if (scr) begin
          proc_addr = addr;
          proc_read = 1'b1;
          scr = 0;
        end
      end
    end
    check("read_done", 128'(done), 128'(1));
    @(posedge clk);
    #1;
    gap = $urandom_range(0, 2);
    if (gap > 0) begin
      proc_read = 1'b0;
      proc_addr = 30'($urandom);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    proc_read  = 1'b0;
    proc_reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    proc_reset = 1'b0;
    model_reset();
  endtask

  task automatic check_counters();
    proc_read = 1'b0;
    @(negedge clk);
`ifdef ICACHE_PERF_CNT_EN
    check("acc_cnt", 128'(acc_cnt), 128'(m_acc));
    check("miss_cnt", 128'(miss_cnt), 128'(m_miss));
`else
    check("acc_cnt", 128'(acc_cnt), 128'(0));
    check("miss_cnt", 128'(miss_cnt), 128'(0));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_alloc(input logic [29:0] addr);
    bit seen = 0;
    mem_lat   = 50;
    proc_addr = addr;
    proc_read = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
    end
    check("alloc_seen", 128'(seen), 128'(1));
    repeat (2) @(negedge clk);
    #1;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    #1;
    check("rst_mem_read", 128'(mem_read), 128'(0));
    check("rst_stall", 128'(proc_stall), 128'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    proc_reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [29:0] a;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_addr  = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    tick       = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_mem_read0", 128'(mem_read), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_stall0", 128'(proc_stall), 128'(0));
    check("rst_hit", 128'(proc_hit), 128'(0));
    check("rst_rdata", 128'(proc_rdata), 128'(0));
    check("rst_acc", 128'(acc_cnt), 128'(0));
    check("rst_miss", 128'(miss_cnt), 128'(0));
    check("mem_write", 128'(mem_write), 128'(0));
    check("mem_wdata", mem_wdata, 128'(0));
    @(posedge clk);
    #1;
    proc_reset = 1'b0;

    // Cold miss with 5-cycle memory, sequential hits, then 10 reads / 3 misses.
    do_read(30'h10, 5);
    do_read(30'h11, 3);
    do_read(30'h12, 3);
    do_read(30'h13, 3);
    do_read(30'h20, 2);
    do_read(30'h21, 2);
    do_read(30'h14, 1);
    do_read(30'h15, 1);
    do_read(30'h16, 1);
    do_read(30'h10, 1);
    check_counters();

    reset_mid_alloc(30'h40);
    do_read(30'h40, 2);
    check_counters();

    // Five tags into set 0; the fifth evicts way 0.
    do_reset();
    do_read(30'h000, 2);
    do_read(30'h100, 2);
    do_read(30'h200, 2);
    do_read(30'h300, 2);
    do_read(30'h400, 2);
    do_read(30'h000, 2);

    // Touch order 0,1,2,3,0,1 then a new tag evicts way 2.
    do_reset();
    do_read(30'h000, 1);
    do_read(30'h100, 1);
    do_read(30'h200, 1);
    do_read(30'h300, 1);
    do_read(30'h000, 1);
    do_read(30'h100, 1);
    do_read(30'h200, 1);
    do_read(30'h300, 1);
    do_read(30'h000, 1);
    do_read(30'h100, 1);
    do_read(30'h500, 3);
    do_read(30'h000, 1);
    do_read(30'h100, 1);
    do_read(30'h200, 2);

    // Random traffic over a small tag pool to force evictions.
    for (int i = 0; i < 200; i++) begin
      a = 30'(($urandom_range(0, 5) << 5) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      do_read(a, $urandom_range(1, 6));
    end
    check_counters();

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
